// File: rtl/led_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_scan
// Description : Row-multiplexed LED dot-matrix scanner with a double-buffered,
//               host-writable frame store. Each row slot opens with a forced-
//               blank window against ghosting. A front/back buffer swap is
//               granted only at the frame boundary.
//               Optional feature macro: LED_PWM_EN. It adds the 4-bit
//               brightness input 'bright' and 16-step on-time modulation of
//               each lit window.
// Ports       : clk            system clock
//               rst            asynchronous active-low reset
//               wr_en          write strobe into the back buffer
//               wr_row         back-buffer row index (rows >= ROWS ignored)
//               wr_data        row pattern, 1 = LED lit
//               swap_req       level request to swap at the next frame end
//               bright         (LED_PWM_EN only) on-time in 1/16 steps
//               swap_ack       one-cycle pulse when a swap takes effect
//               frame_start    one-cycle pulse when row 0 begins
//               dataout        column drive, active-low (0 = lit)
//               U3_138_A       row address to the dot-array 138 decoder
//               U2_138_select  digit-tube decoder enable, tied 0
//               U3_138_select  dot-array decoder enable, tied 1
// Revision    : 1.0  initial release
// ============================================================================
module led_matrix_scan #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SCAN_DIV  = 8192,
    parameter int BLANK_CYC = 64,
    parameter int RA_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [RA_W-1:0] wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap_req,
`ifdef LED_PWM_EN
    input  logic [3:0]      bright,
`endif
    output logic            swap_ack,
    output logic            frame_start,
    output logic [COLS-1:0] dataout,
    output logic [RA_W-1:0] U3_138_A,
    output logic            U2_138_select,
    output logic            U3_138_select
);

    localparam int              PW           = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   c_PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   c_BLANK      = PW'(BLANK_CYC);
    localparam logic [RA_W-1:0] c_ROW_LAST   = RA_W'(ROWS - 1);

    logic [PW-1:0]   r_presc;
    logic [RA_W-1:0] r_row;
    logic            r_front_sel;
    logic [COLS-1:0] r_buf [2][ROWS];
    logic [COLS-1:0] r_dataout;
    logic            r_frame_start;
    logic            r_swap_ack;

    logic            w_presc_wrap;
    logic            w_frame_end;
    logic            w_swap;
    logic [PW-1:0]   w_nxt_presc;
    logic [RA_W-1:0] w_nxt_row;
    logic            w_nxt_sel;
    logic            w_row_ok;
    logic            w_wr_go;
    logic [COLS-1:0] w_row_pat;
    logic            w_lit;
    logic            w_pwm_on;

    // Rows beyond ROWS-1 only exist when ROWS is not a power of two.
    generate
        if (ROWS == (1 << RA_W)) begin : g_row_full
            assign w_row_ok = 1'b1;
        end else begin : g_row_part
            assign w_row_ok = (wr_row <= c_ROW_LAST);
        end
    endgenerate

    assign w_presc_wrap = (r_presc == c_PRESC_LAST);
    assign w_frame_end  = w_presc_wrap && (r_row == c_ROW_LAST);
    assign w_swap       = w_frame_end && swap_req;
    assign w_nxt_presc  = w_presc_wrap ? '0 : r_presc + 1'b1;
    assign w_nxt_sel    = r_front_sel ^ w_swap;
    assign w_wr_go      = wr_en && w_row_ok;

    always_comb begin
        w_nxt_row = r_row;
        if (w_presc_wrap) begin
            w_nxt_row = (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
        end
    end

    // The outputs are registered from next-state values, so the address and
    // columns change on the same edge. On a swap edge the write lands in the
    // buffer that becomes front. Forward it so the first row shows the new
    // data without a stale cycle.
    always_comb begin
        w_row_pat = r_buf[w_nxt_sel][w_nxt_row];
        if (w_wr_go && w_swap && (wr_row == w_nxt_row)) begin
            w_row_pat = wr_data;
        end
    end

    assign w_lit = (w_nxt_presc >= c_BLANK);

`ifdef LED_PWM_EN
    logic [3:0]  r_bright;
    logic [3:0]  w_bright_nxt;
    logic [31:0] w_pwm_pos;
    logic [31:0] w_pwm_lim;

    // Brightness is latched on the edge that starts a new row slot.
    assign w_bright_nxt = w_presc_wrap ? bright : r_bright;
    // Sub-period k = floor(16*pos / W) is lit when k < bright. That is the same as
    // 16*pos < bright*W, which avoids a divider. pos underflows inside
    // the blank window, but w_lit masks that case.
    assign w_pwm_pos = (32'(w_nxt_presc) - 32'(BLANK_CYC)) << 4;
    assign w_pwm_lim = 32'(w_bright_nxt) * 32'(SCAN_DIV - BLANK_CYC);
    assign w_pwm_on  = (w_pwm_pos < w_pwm_lim);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bright <= '0;
        end else begin
            r_bright <= w_bright_nxt;
        end
    end
`else
    assign w_pwm_on = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc       <= '0;
            r_row         <= '0;
            r_front_sel   <= 1'b0;
            r_dataout     <= '1;
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                r_buf[0][r] <= '0;
                r_buf[1][r] <= '0;
            end
        end else begin
            r_presc       <= w_nxt_presc;
            r_row         <= w_nxt_row;
            r_front_sel   <= w_nxt_sel;
            r_frame_start <= w_frame_end;
            r_swap_ack    <= w_swap;
            r_dataout     <= (w_lit && w_pwm_on) ? ~w_row_pat : '1;
            // Writes always target the pre-edge back buffer.
            if (w_wr_go) begin
                r_buf[~r_front_sel][wr_row] <= wr_data;
            end
        end
    end

    assign dataout       = r_dataout;
    assign U3_138_A      = r_row;
    assign frame_start   = r_frame_start;
    assign swap_ack      = r_swap_ack;
    assign U2_138_select = 1'b0;
    assign U3_138_select = 1'b1;

endmodule
`default_nettype wire
